picorv32_mem_arbiter: RTL
=========================

PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

Interface
- REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 255: slave-response timeout in cycles; 0 disables the timeout.
- REQ-002 SHALL provide clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003 SHALL provide reset  input  1  synchronous, active-high reset.
- REQ-004 SHALL provide mN_mem_valid (N=0,1)  input  1  requester N access request; held until its mN_mem_ready.
- REQ-005 SHALL provide mN_mem_instr  input  1  requester N instruction-fetch flag.
- REQ-006 SHALL provide mN_mem_addr  input  32  requester N byte address.
- REQ-007 SHALL provide mN_mem_wdata  input  32  requester N write data.
- REQ-008 SHALL provide mN_mem_wstrb  input  4  requester N byte strobes; 0 means read.
- REQ-009 SHALL provide mN_mem_ready  output  1  one-cycle completion pulse to requester N.
- REQ-010 SHALL provide mN_mem_rdata  output  32  read data to requester N, valid while mN_mem_ready=1.
- REQ-011 SHALL provide mem_valid, mem_instr  output  1 each  shared-port request and fetch flag (to the AXI adapter).
- REQ-012 SHALL provide mem_addr  output  32; mem_wdata  output  32; mem_wstrb  output  4  shared-port request fields.
- REQ-013 SHALL provide mem_ready  input  1; mem_rdata  input  32  shared-port completion and read data.
- REQ-014 SHALL provide err  output  1  one-cycle pulse on timeout completion.

Function
- REQ-015 SHALL implement states IDLE, BUS, RESP; exactly one transaction outstanding at any time.
- REQ-016 In IDLE with one requester valid, SHALL grant it; with none, SHALL remain in IDLE.
- REQ-017 In IDLE with both valid, SHALL grant per the arbitration policy (REQ-027/028) and record the grant in last_grant.
- REQ-018 On grant, SHALL register addr/wdata/wstrb/instr from the granted requester and enter BUS; mem_valid=1 in the cycle after the request was sampled (1-cycle request latency).
- REQ-019 In BUS, mem_valid and all mem_* request fields SHALL stay constant until completion, regardless of requester input changes.
- REQ-020 In BUS, mem_ready=1 SHALL register mem_rdata, deassert mem_valid next cycle, enter RESP.
- REQ-021 In RESP, SHALL drive the granted mN_mem_ready=1 with the registered rdata for exactly one cycle, then return to IDLE; the non-granted ready SHALL stay 0.
- REQ-022 The cycle count from grant to completion SHALL be counted from BUS entry; on reaching TIMEOUT_CYCLES (nonzero) without mem_ready, SHALL deassert mem_valid, enter RESP with rdata 32'h0000_0000 and pulse err coincident with mN_mem_ready.
- REQ-023 mem_ready asserted in the same cycle the timeout count is reached SHALL be treated as normal completion (no err).
- REQ-024 mem_ready while not in BUS SHALL be ignored.
- REQ-025 A requester deasserting valid before being granted SHALL simply lose its request; no completion is issued.

Reset
- REQ-026 reset=1 SHALL, on the next edge, force state IDLE, last_grant=1, timeout count 0, and all outputs (mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mN_mem_ready, mN_mem_rdata, err) to 0, aborting any transaction in progress without a completion pulse.

Configuration
- REQ-027 With MEM_ARB_ROUND_ROBIN_EN defined, SHALL resolve a simultaneous request to the requester not equal to last_grant (m0 first after reset).
- REQ-028 Without MEM_ARB_ROUND_ROBIN_EN, SHALL always grant m0 on a simultaneous request; last_grant is still updated but unused.

Verification
- REQ-029 m0 read 0x0000_0100 alone, mem_ready 2 cycles after mem_valid with rdata 0xA5A5_A5A5 -> mem_valid 1 cycle after request, m0_mem_ready one cycle with 0xA5A5_A5A5, m1_mem_ready stays 0.
- REQ-030 m1 write 0x0000_2000, wdata 0x1234_5678, wstrb 0xF -> mem_addr/wdata/wstrb exactly those values, held stable through a 5-cycle mem_ready delay.
- REQ-031 Both request continuously after reset -> with macro: grants m0, m1, m0, m1; without macro: m0 on every arbitration while m0 requests.
- REQ-032 TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_valid drops after 4 BUS cycles, m0_mem_ready and err pulse together, rdata 0.
- REQ-033 reset pulsed mid-BUS -> next cycle all outputs 0, no mN_mem_ready pulse; subsequent m1 request served normally.

Source files
------------

// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter sharing one PicoRV32-style memory port, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: m0 priority).
module picorv32_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]  req_valid;
    logic        req_instr [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];

    always_comb begin
        req_valid    = {m1_mem_valid, m0_mem_valid};
        req_instr[0] = m0_mem_instr;
        req_instr[1] = m1_mem_instr;
        req_addr[0]  = m0_mem_addr;
        req_addr[1]  = m1_mem_addr;
        req_wdata[0] = m0_mem_wdata;
        req_wdata[1] = m1_mem_wdata;
        req_wstrb[0] = m0_mem_wstrb;
        req_wstrb[1] = m1_mem_wstrb;
    end

    logic [1:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_instr_q, mem_instr_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    ready_q, ready_d;
    logic          err_q, err_d;
    logic          sel;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_instr_d  = mem_instr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        rdata_d      = rdata_q;
        ready_d      = 2'b00;
        err_d        = 1'b0;
        sel          = ~req_valid[0];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (&req_valid)
            sel = ~last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    cnt_d        = '0;
                    mem_valid_d  = 1'b1;
                    mem_instr_d  = req_instr[sel];
                    mem_addr_d   = req_addr[sel];
                    mem_wdata_d  = req_wdata[sel];
                    mem_wstrb_d  = req_wstrb[sel];
                    state_d      = S_BUS;
                end
            end
            S_BUS: begin
                // A response arriving on the timeout cycle wins over the timeout.
                if (mem_ready) begin
                    rdata_d          = mem_rdata;
                    mem_valid_d      = 1'b0;
                    ready_d[grant_q] = 1'b1;
                    state_d          = S_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    rdata_d          = 32'h0000_0000;
                    mem_valid_d      = 1'b0;
                    ready_d[grant_q] = 1'b1;
                    err_d            = 1'b1;
                    state_d          = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            rdata_q      <= '0;
            ready_q      <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_instr_q  <= mem_instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_instr    = mem_instr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign err          = err_q;
    assign m0_mem_ready = ready_q[0];
    assign m1_mem_ready = ready_q[1];
    assign m0_mem_rdata = ready_q[0] ? rdata_q : 32'h0000_0000;
    assign m1_mem_rdata = ready_q[1] ? rdata_q : 32'h0000_0000;
endmodule
